// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX->MEM pipeline register with valid/ready, flush and optional skid entry (PIPE_SKID_EN)
module ex_mem_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] d2_in,
    input  logic [REG_AW-1:0] wreg_in,
    input  logic              rwrite_in,
    input  logic              mreg_in,
    input  logic              mread_in,
    input  logic              mwrite_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] d2_out,
    output logic [REG_AW-1:0] wreg_out,
    output logic              rwrite_out,
    output logic              mreg_out,
    output logic              mread_out,
    output logic              mwrite_out,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PW = 2*DATA_W + REG_AW + 4;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q, main_d;
    logic          main_vld_q, main_vld_d;
    logic          accept, issue;

    assign in_pl  = {alu_in, d2_in, wreg_in, rwrite_in, mreg_in, mread_in, mwrite_in};
    assign accept = in_valid & in_ready;
    assign issue  = main_vld_q & out_ready;

`ifdef PIPE_SKID_EN
    logic [PW-1:0] skid_q, skid_d;
    logic          skid_vld_q, skid_vld_d;

    // Ready comes straight from a flop so out_ready never reaches in_ready.
    assign in_ready = !skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            if (accept) begin
                main_d     = in_pl;
                main_vld_d = 1'b1;
            end
        end else if (issue) begin
            // A full skid blocks accept, so the skid refill and a new accept never collide.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = in_pl;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_pl;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign in_ready = !main_vld_q | out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = in_pl;
            main_vld_d = 1'b1;
        end else if (issue) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    logic rwrite_raw, mreg_raw, mread_raw, mwrite_raw;

    assign {alu_out, d2_out, wreg_out, rwrite_raw, mreg_raw, mread_raw, mwrite_raw} = main_q;

    // Gate control bits so a bubble can never write the register file or memory.
    assign out_valid  = main_vld_q;
    assign rwrite_out = rwrite_raw & main_vld_q;
    assign mreg_out   = mreg_raw & main_vld_q;
    assign mread_out  = mread_raw & main_vld_q;
    assign mwrite_out = mwrite_raw & main_vld_q;

    assign fwd_en   = main_vld_q & rwrite_raw & !mread_raw & (wreg_out != '0);
    assign fwd_reg  = wreg_out;
    assign fwd_data = alu_out;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - scoreboard bench for ex_mem_pipe_reg with randomized traffic
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] d2;
        logic [2:0]  wreg;
        logic        rw;
        logic        mreg;
        logic        mrd;
        logic        mwr;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_in = '0;
    logic [15:0] d2_in = '0;
    logic [2:0]  wreg_in = '0;
    logic        rwrite_in = 1'b0;
    logic        mreg_in = 1'b0;
    logic        mread_in = 1'b0;
    logic        mwrite_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_out, d2_out, fwd_data;
    logic [2:0]  wreg_out, fwd_reg;
    logic        rwrite_out, mreg_out, mread_out, mwrite_out, fwd_en;

    int n_checks = 0;
    int n_fail = 0;

    item_t exp_q[$];
    item_t pend_q[$];

    ex_mem_pipe_reg #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_in(alu_in), .d2_in(d2_in), .wreg_in(wreg_in),
        .rwrite_in(rwrite_in), .mreg_in(mreg_in), .mread_in(mread_in), .mwrite_in(mwrite_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .d2_out(d2_out), .wreg_out(wreg_out),
        .rwrite_out(rwrite_out), .mreg_out(mreg_out), .mread_out(mread_out), .mwrite_out(mwrite_out),
        .fwd_en(fwd_en), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it      = '0;
        it.alu  = 16'($urandom);
        it.d2   = 16'($urandom);
        it.wreg = 3'($urandom);
        it.rw   = 1'($urandom);
        it.mreg = 1'($urandom);
        it.mrd  = 1'($urandom);
        it.mwr  = 1'($urandom);
        return it;
    endfunction

    function automatic item_t mk(input logic [15:0] alu, input logic [2:0] wreg,
                                 input logic rw, input logic mrd, input logic mwr);
        item_t it;
        it      = rand_item();
        it.alu  = alu;
        it.wreg = wreg;
        it.rw   = rw;
        it.mrd  = mrd;
        it.mwr  = mwr;
        it.mreg = mrd;
        return it;
    endfunction

    // One clock of stimulus: present the oldest pending item, record acceptance after the edge.
    task automatic step(input bit ordy, input bit fl, input bit offer);
        item_t it;
        bit    acc;
        if (offer && pend_q.size() > 0) begin
            it       = pend_q[0];
            in_valid = 1'b1;
        end else begin
            it       = rand_item();
            in_valid = 1'b0;
        end
        {alu_in, d2_in, wreg_in, rwrite_in, mreg_in, mread_in, mwrite_in} = it;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) begin
            void'(pend_q.pop_front());
            if (!fl && !rst) exp_q.push_back(it);
        end
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            step(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("drain_left", 64'(pend_q.size() + exp_q.size()), 64'd0);
    endtask

    // Monitor: compares what MEM sees against the head of the expected queue.
    initial begin
        item_t h;
        bit    ev, er, iss, fl, ef;
        forever begin
            @(negedge clk);
            iss = 1'b0;
            fl  = 1'b0;
            if (!rst) begin
                ev = exp_q.size() != 0;
`ifdef PIPE_SKID_EN
                er = exp_q.size() < 2;
`else
                er = (exp_q.size() == 0) || out_ready;
`endif
                chk("out_valid", 64'(out_valid), 64'(ev));
                chk("in_ready", 64'(in_ready), 64'(er));
                if (ev) begin
                    h  = exp_q[0];
                    ef = h.rw && !h.mrd && (h.wreg != 3'd0);
                    chk("payload", 64'({alu_out, d2_out, wreg_out, rwrite_out, mreg_out, mread_out, mwrite_out}),
                        64'(h));
                    chk("forward", 64'({fwd_en, fwd_reg, fwd_data}), 64'({ef, h.wreg, h.alu}));
                end else begin
                    chk("bubble_ctrl", 64'({rwrite_out, mreg_out, mread_out, mwrite_out, fwd_en}), 64'd0);
                end
                iss = ev && out_ready;
                fl  = flush;
            end
            @(posedge clk);
            if (iss && exp_q.size() > 0) h = exp_q.pop_front();
            if (fl) exp_q.delete();
        end
    end

    initial begin
        #1;
        chk("reset_outs", 64'({out_valid, alu_out, d2_out, wreg_out, rwrite_out, mreg_out, mread_out,
                               mwrite_out, fwd_en, fwd_reg, fwd_data}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic flow with forwarding
        pend_q.push_back(mk(16'h1234, 3'd3, 1'b1, 1'b0, 1'b0));
        drain(10);

        // Stall with AAAA held, BBBB and CCCC waiting behind it
        pend_q.push_back(mk(16'hAAAA, 3'd1, 1'b1, 1'b0, 1'b0));
        pend_q.push_back(mk(16'hBBBB, 3'd2, 1'b1, 1'b0, 1'b0));
        pend_q.push_back(mk(16'hCCCC, 3'd4, 1'b0, 1'b0, 1'b1));
        repeat (5) step(1'b0, 1'b0, 1'b1);
        drain(20);

        // Flush kills held entries and a simultaneous accept
        pend_q.push_back(mk(16'h7777, 3'd5, 1'b1, 1'b0, 1'b1));
        step(1'b0, 1'b0, 1'b1);
        pend_q.push_back(mk(16'h5555, 3'd6, 1'b1, 1'b0, 1'b1));
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        chk("flush_drop", 64'(exp_q.size() + pend_q.size()), 64'd0);

        // Loads and writes to r0 are not forwarded
        pend_q.push_back(mk(16'h0F0F, 3'd2, 1'b1, 1'b1, 1'b0));
        pend_q.push_back(mk(16'h3C3C, 3'd0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        drain(10);

        // Eight back-to-back stores under random backpressure
        for (int i = 0; i < 8; i++) pend_q.push_back(mk(16'($urandom), 3'($urandom), 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 60 && (pend_q.size() > 0 || exp_q.size() > 0); i++)
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        drain(20);

        // Reset in the middle of a stall discards everything at once
        pend_q.push_back(mk(16'h1111, 3'd1, 1'b1, 1'b0, 1'b1));
        pend_q.push_back(mk(16'h2222, 3'd2, 1'b1, 1'b0, 1'b1));
        repeat (3) step(1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 64'({out_valid, alu_out, d2_out, wreg_out, rwrite_out, mreg_out, mread_out,
                                 mwrite_out, fwd_en}), 64'd0);
        exp_q.delete();
        pend_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            if (pend_q.size() < 3 && $urandom_range(0, 3) != 0) pend_q.push_back(rand_item());
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 4) != 0));
        end
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
